// File: rtl/unidade_controle_polilock_pkg.sv
// unidade_controle_polilock_pkg: state encodings and command codes for the Polilock controller
package unidade_controle_polilock_pkg;
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        ESPERA      = 4'h1,
        V_ZERA      = 4'h2,
        V_ESPERA    = 4'h3,
        V_COMPARA   = 4'h4,
        V_CONTA     = 4'h5,
        ACERTO      = 4'h6,
        ERRO        = 4'h7,
        CHECA       = 4'h8,
        BLOQUEADO   = 4'h9,
        DESTRANCADO = 4'hA,
        G_ZERA      = 4'hB,
        G_ESPERA    = 4'hC,
        G_ESCREVE   = 4'hD,
        G_CONTA     = 4'hE
    } estado_t;
    localparam logic [1:0] FUNC_VERIFICA = 2'b01;
    localparam logic [1:0] FUNC_GRAVA    = 2'b10;
    localparam logic [1:0] FUNC_TRANCA   = 2'b11;
endpackage

// File: rtl/unidade_controle_polilock_temporizador.sv
// unidade_controle_polilock_temporizador: down-counter that loads on state entry and flags expiry
module unidade_controle_polilock_temporizador #(
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_tick,
    output logic         o_expirou
);
    logic [W-1:0] r_count;
    // Outside a timed state the counter is held at zero.
    always_ff @(posedge i_clock) begin
        if (i_reset || !(i_load || i_tick)) r_count <= '0;
        else if (i_load)                    r_count <= i_value;
        else if (r_count != '0)             r_count <= r_count - 1'b1;
    end
    assign o_expirou = i_tick && (r_count == '0);
endmodule

// File: rtl/unidade_controle_polilock.sv
// unidade_controle_polilock: Moore FSM sequencing verify, password write, lock,
// attempt lockout and auto-relock for the Polilock datapath.
module unidade_controle_polilock
    import unidade_controle_polilock_pkg::*;
#(
    parameter int BLOQUEIO_CICLOS  = 50_000_000,
    parameter int DESTRANCA_CICLOS = 250_000_000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_funcao,
    input  logic       i_funcao_selecionada,
    input  logic       i_igual,
    input  logic       i_fim_verificacao,
    input  logic       i_excedeu,
    output logic       o_zera_c,
    output logic       o_conta_c,
    output logic       o_zera_t,
    output logic       o_conta_t,
    output logic       o_escreve,
    output logic       o_destrancado,
    output logic       o_bloqueado,
    output logic [3:0] o_db_estado
);
    localparam int        MAXC = (BLOQUEIO_CICLOS > DESTRANCA_CICLOS) ? BLOQUEIO_CICLOS : DESTRANCA_CICLOS;
    localparam int        TW   = $clog2(MAXC) + 1;
    localparam bit        AUTO = DESTRANCA_CICLOS != 0;
    localparam logic [TW-1:0] L_BLOQ = TW'(BLOQUEIO_CICLOS - 1);
    localparam logic [TW-1:0] L_DEST = AUTO ? TW'(DESTRANCA_CICLOS - 1) : '0;
    estado_t         r_estado, w_proximo;
    logic            w_load, w_tick, w_expirou, w_grava, w_tranca;
    logic [TW-1:0]   w_valor;
    always_ff @(posedge i_clock) begin
        r_estado <= i_reset ? INICIAL : w_proximo;
    end
    // Timer reloads only on a transition into a timed state, so self-loops keep counting.
    assign w_tick  = (r_estado == BLOQUEADO) || (r_estado == DESTRANCADO);
    assign w_load  = (w_proximo != r_estado) && ((w_proximo == BLOQUEADO) || (w_proximo == DESTRANCADO));
    assign w_valor = (w_proximo == BLOQUEADO) ? L_BLOQ : L_DEST;
    assign w_grava  = i_funcao_selecionada && (i_funcao == FUNC_GRAVA);
    assign w_tranca = i_funcao_selecionada && (i_funcao == FUNC_TRANCA);
    unidade_controle_polilock_temporizador #(.W(TW)) u_temporizador (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_load   (w_load),
        .i_value  (w_valor),
        .i_tick   (w_tick),
        .o_expirou(w_expirou)
    );
    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:     w_proximo = ESPERA;
            ESPERA:      w_proximo = (i_funcao_selecionada && i_funcao == FUNC_VERIFICA) ? V_ZERA : ESPERA;
            V_ZERA:      w_proximo = V_ESPERA;
            V_ESPERA:    w_proximo = V_COMPARA;
            V_COMPARA:   w_proximo = !i_igual ? ERRO : i_fim_verificacao ? ACERTO : V_CONTA;
            V_CONTA:     w_proximo = V_ESPERA;
            ACERTO:      w_proximo = DESTRANCADO;
            ERRO:        w_proximo = CHECA;
            CHECA:       w_proximo = i_excedeu ? BLOQUEADO : ESPERA;
            BLOQUEADO:   w_proximo = w_expirou ? INICIAL : BLOQUEADO;
            DESTRANCADO: w_proximo = w_grava ? G_ZERA : w_tranca ? ESPERA :
                                     (AUTO && w_expirou) ? ESPERA : DESTRANCADO;
            G_ZERA:      w_proximo = G_ESPERA;
            G_ESPERA:    w_proximo = G_ESCREVE;
            G_ESCREVE:   w_proximo = i_fim_verificacao ? DESTRANCADO : G_CONTA;
            G_CONTA:     w_proximo = G_ESPERA;
            default:     w_proximo = INICIAL;
        endcase
        o_zera_c      = (r_estado == INICIAL) || (r_estado == V_ZERA) || (r_estado == G_ZERA);
        o_conta_c     = (r_estado == V_CONTA) || (r_estado == G_CONTA);
        o_zera_t      = (r_estado == INICIAL) || (r_estado == ACERTO);
        o_conta_t     = r_estado == ERRO;
        o_escreve     = r_estado == G_ESCREVE;
        o_destrancado = r_estado == DESTRANCADO;
        o_bloqueado   = r_estado == BLOQUEADO;
        o_db_estado   = r_estado;
    end
endmodule

// File: tb/tb_unidade_controle_polilock.sv
// tb_unidade_controle_polilock: controller bench with a behavioural datapath model
// (counters, RAM, ROM) and a cycle-stamped scoreboard of expected output vectors.
module tb_unidade_controle_polilock;
    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [1:0] i_funcao = 2'b00;
    logic       i_funcao_selecionada = 1'b0;
    logic       zc, cc, zt, ct, esc, des, blq;
    logic [3:0] db;
    logic [10:0] w_vec;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Datapath model: sequence/attempt counters, stored password RAM, entered-chars ROM.
    logic [3:0] r_seq, r_att;
    logic [7:0] ram [16];
    logic [7:0] rom [16];
    logic [7:0] ram_q, rom_q;
    logic       tb_ram_load = 1'b0;
    always @(posedge clk) begin
        if (zc) r_seq <= 4'd0; else if (cc) r_seq <= r_seq + 4'd1;
        if (zt) r_att <= 4'd0; else if (ct) r_att <= r_att + 4'd1;
        ram_q <= ram[r_seq];
        rom_q <= rom[r_seq];
        if (tb_ram_load) for (int i = 0; i < 10; i++) ram[i] <= rom[i];
        else if (esc) ram[r_seq] <= rom_q;
    end
    unidade_controle_polilock #(.BLOQUEIO_CICLOS(20), .DESTRANCA_CICLOS(40)) dut (
        .i_clock             (clk),
        .i_reset             (i_reset),
        .i_funcao            (i_funcao),
        .i_funcao_selecionada(i_funcao_selecionada),
        .i_igual             (ram_q == rom_q),
        .i_fim_verificacao   (r_seq == 4'd9),
        .i_excedeu           (r_att == 4'd3),
        .o_zera_c            (zc),
        .o_conta_c           (cc),
        .o_zera_t            (zt),
        .o_conta_t           (ct),
        .o_escreve           (esc),
        .o_destrancado       (des),
        .o_bloqueado         (blq),
        .o_db_estado         (db)
    );
    assign w_vec = {zc, cc, zt, ct, esc, des, blq, db};
    // Expected vectors {zeraC,contaC,zeraT,contaT,escreve,destrancado,bloqueado,db_estado}
    localparam logic [10:0] E_INI  = {7'b1010000, 4'h0};
    localparam logic [10:0] E_ESP  = {7'b0000000, 4'h1};
    localparam logic [10:0] E_VZ   = {7'b1000000, 4'h2};
    localparam logic [10:0] E_VCMP = {7'b0000000, 4'h4};
    localparam logic [10:0] E_VCNT = {7'b0100000, 4'h5};
    localparam logic [10:0] E_ACE  = {7'b0010000, 4'h6};
    localparam logic [10:0] E_ERR  = {7'b0001000, 4'h7};
    localparam logic [10:0] E_CHK  = {7'b0000000, 4'h8};
    localparam logic [10:0] E_BLQ  = {7'b0000001, 4'h9};
    localparam logic [10:0] E_DES  = {7'b0000010, 4'hA};
    localparam logic [10:0] E_GZ   = {7'b1000000, 4'hB};
    localparam logic [10:0] E_GESC = {7'b0000100, 4'hD};
    typedef struct { int cyc; logic [10:0] exp; string name; } exp_t;
    exp_t sb[$];
    exp_t e;
    int t, u, b, v, w, d, v2, ev, v3, f, deadline, nesc;
    logic [15:0] wmask;
    logic ok;
    task automatic push(input int c, input logic [10:0] x, input string n);
        sb.push_back('{cyc: c, exp: x, name: n});
    endtask
    task test_reset;
        t = cyc + 1;
        push(t + 1, E_INI, "reset_hold");
        push(t + 2, E_INI, "reset_hold2");
        push(t + 3, E_ESP, "reset_release");
        push(t + 4, E_ESP, "espera_ignores_10");
        push(t + 5, E_ESP, "espera_ignores_11");
        deadline = cyc + 50;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_reset = (cyc == t) || (cyc == t + 1);
            i_funcao_selecionada = (cyc == t + 3) || (cyc == t + 4);
            i_funcao = (cyc == t + 3) ? 2'b10 : 2'b11;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_reset timeout: %0d pending", sb.size()); sb.delete(); end
        end
    endtask
    task test_verify_ok;
        t = cyc + 1;
        push(t + 1,  E_VZ,   "v_zera");
        push(t + 3,  E_VCMP, "first_compare");
        push(t + 4,  E_VCNT, "v_conta");
        push(t + 30, E_VCMP, "last_compare");
        push(t + 31, E_ACE,  "acerto_zerat");
        push(t + 32, E_DES,  "unlocked");
        push(t + 33, E_DES,  "unlocked_hold");
        push(t + 34, E_ESP,  "lock_11");
        deadline = cyc + 100;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_funcao_selecionada = (cyc == t) || (cyc == t + 33);
            i_funcao = (cyc == t) ? 2'b01 : 2'b11;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_verify_ok timeout: %0d pending", sb.size()); sb.delete(); end
        end
    endtask
    task test_verify_fail;
        rom[4] = rom[4] ^ 8'h01;
        t = cyc + 1;
        push(t + 15, E_VCMP, "compare_char4");
        push(t + 16, E_ERR,  "erro_contat");
        push(t + 17, E_CHK,  "checa");
        push(t + 18, E_ESP,  "back_to_espera");
        deadline = cyc + 60;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_funcao_selecionada = (cyc == t);
            i_funcao = 2'b01;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_verify_fail timeout: %0d pending", sb.size()); sb.delete(); end
        end
        total++;
        if (r_att !== 4'd1) begin bad++; $display("FAIL attempts_after_fail: got=%0d want=1", r_att); end
    endtask
    task test_lockout;
        t = cyc + 1;
        u = t + 19;
        b = u + 18;
        push(t + 16, E_ERR, "fail2_erro");
        push(t + 18, E_ESP, "fail2_espera");
        push(u + 16, E_ERR, "fail3_erro");
        push(u + 17, E_CHK, "fail3_checa");
        push(b,      E_BLQ, "blocked_entry");
        push(b + 6,  E_BLQ, "blocked_ignores_01");
        push(b + 11, E_BLQ, "blocked_ignores_11");
        push(b + 13, E_BLQ, "blocked_ignores_10");
        push(b + 19, E_BLQ, "blocked_last");
        push(b + 20, E_INI, "lockout_over");
        push(b + 21, E_ESP, "lockout_espera");
        deadline = cyc + 120;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_funcao_selecionada = (cyc == t) || (cyc == u) || (cyc == b + 5) || (cyc == b + 10) || (cyc == b + 12);
            i_funcao = (cyc == b + 10) ? 2'b11 : (cyc == b + 12) ? 2'b10 : 2'b01;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_lockout timeout: %0d pending", sb.size()); sb.delete(); end
        end
        total++;
        if (r_att !== 4'd0) begin bad++; $display("FAIL attempts_after_lockout: got=%0d want=0", r_att); end
        rom[4] = rom[4] ^ 8'h01;
    endtask
    task test_write;
        t = cyc + 1;
        push(t + 32, E_DES, "unlock_before_write");
        deadline = cyc + 60;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_funcao_selecionada = (cyc == t);
            i_funcao = 2'b01;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_write unlock timeout: %0d pending", sb.size()); sb.delete(); end
        end
        for (int i = 0; i < 10; i++) rom[i] = 8'h41 + 8'(3 * i);
        w = cyc + 1;
        v = w + 34;
        push(w + 1,  E_GZ,   "g_zera");
        push(w + 3,  E_GESC, "first_write");
        push(w + 30, E_GESC, "last_write");
        push(w + 31, E_DES,  "write_done");
        push(w + 33, E_ESP,  "lock_after_write");
        push(v + 31, E_ACE,  "new_pw_acerto");
        push(v + 32, E_DES,  "new_pw_unlocked");
        nesc = 0;
        wmask = '0;
        deadline = cyc + 120;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_funcao_selecionada = (cyc == w) || (cyc == w + 32) || (cyc == v);
            i_funcao = (cyc == w) ? 2'b10 : (cyc == v) ? 2'b01 : 2'b11;
            if (esc) begin nesc++; wmask[r_seq] = 1'b1; end
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_write timeout: %0d pending", sb.size()); sb.delete(); end
        end
        total++;
        if (nesc != 10) begin bad++; $display("FAIL escreve_cycles: got=%0d want=10", nesc); end
        total++;
        if (wmask !== 16'h03FF) begin bad++; $display("FAIL write_addresses: got=%h want=03ff", wmask); end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) if (ram[i] !== 8'h41 + 8'(3 * i)) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL ram_contents: got=%h want=41", ram[0]); end
    endtask
    task test_autorelock;
        d  = cyc;
        v2 = d + 41;
        ev = v2 + 32;
        v3 = ev + 41;
        f  = v3 + 32;
        push(d + 2,   E_DES,  "destr_ignores_01");
        push(d + 39,  E_DES,  "destr_before_expiry");
        push(d + 40,  E_ESP,  "auto_relock");
        push(ev,      E_DES,  "relock2_unlocked");
        push(ev + 39, E_DES,  "expiry_edge_state");
        push(ev + 40, E_ESP,  "lock_on_expiry_edge");
        push(f,       E_DES,  "relock3_unlocked");
        push(f + 39,  E_DES,  "expiry_edge_state2");
        push(f + 40,  E_GZ,   "write_beats_expiry");
        push(f + 42,  E_GESC, "write2_first");
        push(f + 69,  E_GESC, "write2_last");
        push(f + 70,  E_DES,  "write2_done");
        push(f + 72,  E_ESP,  "write2_lock");
        deadline = cyc + 260;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_funcao_selecionada = (cyc == d + 1) || (cyc == v2) || (cyc == ev + 39) || (cyc == v3) ||
                                   (cyc == f + 39) || (cyc == f + 71);
            i_funcao = (cyc == d + 1 || cyc == v2 || cyc == v3) ? 2'b01 : (cyc == f + 39) ? 2'b10 : 2'b11;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_autorelock timeout: %0d pending", sb.size()); sb.delete(); end
        end
    endtask
    task test_reset_mid;
        t = cyc + 1;
        v = t + 6;
        w = v + 33;
        push(t + 3,  E_VCMP, "in_v_compara");
        push(t + 4,  E_INI,  "reset_from_v_compara");
        push(t + 5,  E_ESP,  "espera_after_reset1");
        push(v + 32, E_DES,  "unlock_for_write");
        push(w + 1,  E_GZ,   "g_zera_mid");
        push(w + 3,  E_GESC, "in_g_escreve");
        push(w + 4,  E_INI,  "reset_from_g_escreve");
        push(w + 5,  E_ESP,  "espera_after_reset2");
        deadline = cyc + 100;
        while (sb.size() != 0) begin
            @(negedge clk);
            i_reset = (cyc == t + 3) || (cyc == w + 3);
            i_funcao_selecionada = (cyc == t) || (cyc == v) || (cyc == w);
            i_funcao = (cyc == w) ? 2'b10 : 2'b01;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); total++;
                if (w_vec !== e.exp) begin bad++; $display("FAIL %s: cyc=%0d got=%h want=%h", e.name, cyc, w_vec, e.exp); end
            end
            if (cyc > deadline) begin total++; bad++; $display("FAIL test_reset_mid timeout: %0d pending", sb.size()); sb.delete(); end
        end
    endtask
    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h30 + 8'(i);
        @(negedge clk);
        tb_ram_load = 1'b1;
        @(negedge clk);
        tb_ram_load = 1'b0;
        test_reset;
        test_verify_ok;
        test_verify_fail;
        test_lockout;
        test_write;
        test_autorelock;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
